tpu_sequencer: RTL and testbench

Parametrised instruction sequencer for the uTPU datapath. It pops a little-endian byte stream from the receive FIFO and assembles multi-byte instruction words. It decodes them and issues one command at a time to the buffer/array units over a valid/ready handshake. It then waits for unit completion, with a timeout, before fetching the next instruction. This block replaces the ad-hoc control process inside the top level with a standalone, width-generic controller that has handshakes, operand words and error handling.

---
 rtl/tpu_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_tpu_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: assembles little-endian instruction words from the rx
// FIFO, decodes them and issues one command at a time with a timeout.
module tpu_sequencer #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int INSTR_WIDTH     = 16,
  parameter int OPCODE_WIDTH    = 3,
  parameter int FLAG_WIDTH      = 3,
  parameter int ADDRESS_SIZE    = 9,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
  input  logic                       rx_valid,
  output logic                       rx_re,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [OPCODE_WIDTH-1:0]    cmd_opcode,
  output logic [FLAG_WIDTH-1:0]      cmd_flags,
  output logic [ADDRESS_SIZE-1:0]    cmd_address,
  output logic [INSTR_WIDTH-1:0]     cmd_operand,
  input  logic                       unit_done,
  output logic                       busy,
  output logic                       halted,
  output logic                       illegal_op,
  output logic                       timeout,
  output logic [COUNT_WIDTH-1:0]     instr_count
);

  localparam int BPW = INSTR_WIDTH / FIFO_DATA_WIDTH;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT_CYCLES - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_RUN   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_INSTR,
    S_DECODE,
    S_FETCH_ADDR,
    S_FETCH_DATA,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT,
    S_ERROR
  } state_e;

  state_e state_q;

  logic [BCW-1:0]          bcnt_q;
  logic [INSTR_WIDTH-1:0]  word_q;
  logic [INSTR_WIDTH-1:0]  word_d;
  logic [WCW-1:0]          wcnt_q;

  logic [OPCODE_WIDTH-1:0] iop_q;
  logic [FLAG_WIDTH-1:0]   iflags_q;
  logic [ADDRESS_SIZE-1:0] iaddr_q;

  logic                    cmd_valid_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [FLAG_WIDTH-1:0]   flags_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [INSTR_WIDTH-1:0]  opnd_q;
  logic                    illegal_q;
  logic                    timeout_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;

  logic fetching;
  logic word_done;
  logic is_store;
  logic is_exec;
  logic is_nop;
  logic is_halt;
  logic ext_addr;

  assign fetching = state_q inside
    {S_FETCH_INSTR, S_FETCH_ADDR, S_FETCH_DATA};
  assign rx_re     = rx_valid && fetching;
  assign word_done = rx_re && (bcnt_q == LAST_BYTE);

  // word_q is cleared between words, so OR-ing the new slice in suffices
  always_comb begin
    word_d = word_q
      | (INSTR_WIDTH'(rx_data) << (int'(bcnt_q) * FIFO_DATA_WIDTH));
  end

  assign is_store = iop_q == OP_STORE;
  assign is_exec  = iop_q inside {OP_FETCH, OP_RUN, OP_LOAD};
  assign is_nop   = iop_q == OP_NOP;
  assign is_halt  = iop_q == OP_HALT;
  assign ext_addr = iflags_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      word_q      <= '0;
      wcnt_q      <= '0;
      iop_q       <= '0;
      iflags_q    <= '0;
      iaddr_q     <= '0;
      cmd_valid_q <= 1'b0;
      op_q        <= '0;
      flags_q     <= '0;
      addr_q      <= '0;
      opnd_q      <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (rx_re) begin
        bcnt_q <= word_done ? '0 : bcnt_q + 1'b1;
        word_q <= word_done ? '0 : word_d;
      end
      unique case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            state_q   <= S_FETCH_INSTR;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_FETCH_INSTR: begin
          if (word_done) begin
            iop_q    <= word_d[OPCODE_WIDTH-1:0];
            iflags_q <=
              word_d[OPCODE_WIDTH+FLAG_WIDTH-1:OPCODE_WIDTH];
            iaddr_q  <= word_d[INSTR_WIDTH-1 -: ADDRESS_SIZE];
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_store || is_exec) begin
            op_q    <= iop_q;
            flags_q <= iflags_q;
            addr_q  <= iaddr_q;
            opnd_q  <= '0;
          end
          unique case (1'b1)
            is_store && ext_addr:  state_q <= S_FETCH_ADDR;
            is_store && !ext_addr: state_q <= S_FETCH_DATA;
            is_exec: begin
              cmd_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
            is_nop: begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_FETCH_INSTR;
            end
            is_halt: begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_HALT;
            end
            default: begin
              illegal_q <= 1'b1;
              state_q   <= S_ERROR;
            end
          endcase
        end
        S_FETCH_ADDR: begin
          if (word_done) begin
            addr_q  <= word_d[ADDRESS_SIZE-1:0];
            state_q <= S_FETCH_DATA;
          end
        end
        S_FETCH_DATA: begin
          if (word_done) begin
            opnd_q      <= word_d;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wcnt_q      <= '0;
            if (unit_done) begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_FETCH_INSTR;
            end else begin
              state_q <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (unit_done) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_FETCH_INSTR;
          end else if (wcnt_q == LAST_WAIT) begin
            timeout_q <= 1'b1;
            state_q   <= S_ERROR;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
  assign halted      = state_q == S_HALT;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = op_q;
  assign cmd_flags   = flags_q;
  assign cmd_address = addr_q;
  assign cmd_operand = opnd_q;
  assign illegal_op  = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: a word-level program model predicts the
// command stream and retire count; FIFO and target unit are randomised.
module tb_tpu_sequencer;

  localparam int FDW  = 8;
  localparam int IW   = 16;
  localparam int OW   = 3;
  localparam int FW   = 3;
  localparam int AW   = 9;
  localparam int TO   = 16;
  localparam int CW   = 16;
  localparam int CMDW = OW + FW + AW + IW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [FDW-1:0] rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           rx_re;
  logic           cmd_valid;
  logic           cmd_ready = 1'b0;
  logic [OW-1:0]  cmd_opcode;
  logic [FW-1:0]  cmd_flags;
  logic [AW-1:0]  cmd_address;
  logic [IW-1:0]  cmd_operand;
  logic           unit_done = 1'b0;
  logic           busy;
  logic           halted;
  logic           illegal_op;
  logic           timeout;
  logic [CW-1:0]  instr_count;

  tpu_sequencer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_re      (rx_re),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_flags  (cmd_flags),
    .cmd_address(cmd_address),
    .cmd_operand(cmd_operand),
    .unit_done  (unit_done),
    .busy       (busy),
    .halted     (halted),
    .illegal_op (illegal_op),
    .timeout    (timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [7:0]      bq[$];
  logic [CMDW-1:0] expq[$];

  int n_chk = 0;
  int n_pass = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  int same_pct = 0;
  bit no_done = 1'b0;
  int cyc = 0;
  int n_pops = 0;
  int n_hs = 0;
  int last_pop = 0;
  int hs_cyc = 0;
  int to_cyc = 0;
  int dwait = -1;
  bit re_l = 1'b0;
  bit hs_l = 1'b0;
  bit same_l = 1'b0;
  bit cv_l = 1'b0;
  bit to_l = 1'b0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [IW-1:0] mk(int op, int fl, int ad);
    logic [IW-1:0] w;
    w = '0;
    w[OW-1:0] = OW'(op);
    w[OW+FW-1:OW] = FW'(fl);
    w[OW+FW] = 1'($urandom);
    w[IW-1 -: AW] = AW'(ad);
    return w;
  endfunction

  function automatic logic [CMDW-1:0] cmd(int op, int fl, int ad,
                                          logic [IW-1:0] d);
    return {OW'(op), FW'(fl), AW'(ad), d};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({rx_re, cmd_valid, cmd_opcode, cmd_flags, cmd_address,
                cmd_operand, busy, halted, illegal_op, timeout,
                instr_count});
  endfunction

  task automatic push_word(input logic [IW-1:0] w);
    bq.push_back(w[7:0]);
    bq.push_back(w[15:8]);
  endtask

  // Target FIFO, target unit and command scoreboard, all at negedge
  always @(negedge clk) begin
    logic [CMDW-1:0] got;
    cyc++;
    if (re_l) begin
      if (bq.size() > 0) void'(bq.pop_front());
      n_pops++;
    end
    unit_done = 1'b0;
    if (hs_l && !same_l && !no_done) dwait = $urandom_range(0, 5);
    if (dwait == 0) begin
      unit_done = 1'b1;
      dwait = -1;
    end else if (dwait > 0) begin
      dwait--;
    end
    rx_valid = (bq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    rx_data = rx_valid ? bq[0] : 8'($urandom);
    cmd_ready = cmd_valid && ($urandom_range(0, 99) < rdy_pct);
    same_l = 1'b0;
    if (cmd_ready && !no_done && $urandom_range(0, 99) < same_pct) begin
      unit_done = 1'b1;
      same_l = 1'b1;
    end
    #1;
    re_l = rx_re;
    hs_l = cmd_valid && cmd_ready;
    if (re_l) last_pop = cyc;
    if (hs_l) begin
      hs_cyc = cyc;
      n_hs++;
    end
    if (timeout && !to_l) to_cyc = cyc;
    to_l = timeout;
    if (cmd_valid) begin
      got = {cmd_opcode, cmd_flags, cmd_address, cmd_operand};
      if (expq.size() == 0) begin
        chk("cmd_unexpected", cmd_valid, 0);
      end else begin
        if (!cv_l && expq[0][CMDW-1 -: OW] != 0)
          chk("latency", cyc - last_pop, 2);
        chk("cmd", got, expq[0]);
        if (cmd_ready) void'(expq.pop_front());
      end
    end
    cv_l = cmd_valid && !cmd_ready;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic bit cond(int kind, int val);
    case (kind)
      0: return instr_count == CW'(val);
      1: return halted;
      2: return illegal_op;
      3: return timeout;
      4: return cmd_valid;
      default: return n_pops >= val;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int kind,
                          input int val = 0);
    int n;
    n = 0;
    while (!cond(kind, val) && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 64'(cond(kind, val)), 1);
  endtask

  task automatic gen_prog(input int n);
    for (int i = 0; i < n; i++) begin
      int op, fl, ad;
      logic [IW-1:0] aw, dw;
      op = $urandom_range(0, 4);
      if (op == 4) op = 5;
      fl = $urandom_range(0, 7);
      ad = $urandom_range(0, 511);
      push_word(mk(op, fl, ad));
      if (op == 0) begin
        if ((fl & 2) != 0) begin
          aw = IW'($urandom);
          push_word(aw);
          ad = int'(aw[AW-1:0]);
        end
        dw = IW'($urandom);
        push_word(dw);
        expq.push_back(cmd(0, fl, ad, dw));
      end else if (op != 5) begin
        expq.push_back(cmd(op, fl, ad, '0));
      end
      exp_cnt++;
    end
    push_word(mk(4, $urandom_range(0, 7), $urandom_range(0, 511)));
    exp_cnt++;
  endtask

  initial begin
    int p0;
    int hs0;
    step(3);
    chk("reset_outs", outs(), 0);
    rst = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);

    // RUN with the target holding off for a while
    rdy_pct = 0;
    push_word(16'h092A);
    expq.push_back(cmd(2, 5, 'h012, '0));
    pulse_start();
    chk("fetch_busy", busy, 1);
    wait_for("run_valid", 4);
    repeat (3) begin
      step();
      chk("run_hold", cmd_valid, 1);
    end
    rdy_pct = 100;
    exp_cnt = 1;
    wait_for("run_retire", 0, exp_cnt);

    // STORE with extended address over a gappy FIFO
    gap_pct = 50;
    p0 = n_pops;
    push_word(16'h0010);
    push_word(16'h01FF);
    push_word(16'hBEEF);
    expq.push_back(cmd(0, 2, 'h1FF, 16'hBEEF));
    exp_cnt++;
    wait_for("st_retire", 0, exp_cnt);
    step();
    chk("st_pops", n_pops - p0, 6);
    chk("st_drained", expq.size(), 0);
    gap_pct = 0;

    // illegal opcode stalls the FIFO until restarted
    p0 = n_pops;
    push_word(16'h0006);
    push_word(16'h0005);
    push_word(16'h0005);
    wait_for("ill_flag", 2);
    step(4);
    chk("ill_busy", busy, 0);
    chk("ill_pops", n_pops - p0, 2);
    chk("ill_left", bq.size(), 4);
    chk("ill_re", rx_re, 0);
    pulse_start();
    chk("ill_clear", illegal_op, 0);
    exp_cnt += 2;
    wait_for("ill_resume", 0, exp_cnt);

    // LOAD accepted but never completed
    no_done = 1'b1;
    push_word(16'h0003);
    expq.push_back(cmd(3, 0, 0, '0));
    wait_for("to_flag", 3);
    step();
    chk("to_delay", to_cyc - hs_cyc - 1, TO);
    chk("to_count", instr_count, exp_cnt);
    chk("to_busy", busy, 0);
    no_done = 1'b0;
    pulse_start();
    chk("to_clear", timeout, 0);

    // HALT leaves the following NOP in the FIFO
    push_word(16'h0004);
    push_word(16'h0005);
    exp_cnt++;
    wait_for("halt", 1);
    step(3);
    chk("halt_count", instr_count, exp_cnt);
    chk("halt_left", bq.size(), 2);
    pulse_start();
    chk("halt_exit", halted, 0);
    exp_cnt++;
    wait_for("nop_retire", 0, exp_cnt);
    chk("nop_drained", bq.size(), 0);

    // reset with half a word assembled
    p0 = n_pops;
    bq.push_back(8'h2A);
    wait_for("rst_pop", 5, p0 + 1);
    rst = 1'b0;
    #1;
    chk("rst_outs", outs(), 0);
    step();
    rst = 1'b1;
    hs0 = n_hs;
    push_word(16'h0005);
    pulse_start();
    exp_cnt = 1;
    wait_for("rst_nop", 0, exp_cnt);
    step(2);
    chk("rst_nocmd", n_hs - hs0, 0);

    // random programs ending in HALT
    for (int r = 0; r < 6; r++) begin
      gap_pct = $urandom_range(0, 60);
      rdy_pct = $urandom_range(30, 100);
      same_pct = $urandom_range(0, 50);
      gen_prog($urandom_range(4, 10));
      if (halted) pulse_start();
      wait_for("rnd_halt", 1);
      step();
      chk("rnd_count", instr_count, exp_cnt);
      chk("rnd_cmds", expq.size(), 0);
      chk("rnd_bytes", bq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
